// File: rtl/dcm_pkg.sv
// dcm_pkg
// Shared definitions for the DC motor channel feedback front end.
//   POS_W            width of the position count
//   SPEED_W          width of the windowed speed measurement
//   FLAG_*_BIT       bit positions of the sticky flags in the SPI status byte
//   drive_mode_t     decoded {drive_left, drive_right} pair
//   pack_status()    packs the sticky flags into the SPI status byte layout
package dcm_pkg;

   localparam int POS_W   = 24;
   localparam int SPEED_W = 8;

   localparam int FLAG_FAULT_BIT   = 0;
   localparam int FLAG_OTW_BIT     = 1;
   localparam int FLAG_STALLED_BIT = 2;

   // Encoded as {drive_left, drive_right}; coast and brake both leave the
   // direction register alone.
   typedef enum logic [1:0] {
      DRIVE_COAST = 2'b00,
      DRIVE_RIGHT = 2'b01,
      DRIVE_LEFT  = 2'b10,
      DRIVE_BRAKE = 2'b11
   } drive_mode_t;

   // Builds the status byte the channel logic ships over SPI.
   function automatic logic [7:0] pack_status(input logic fault,
                                              input logic otw,
                                              input logic stalled);
      logic [7:0] status;
      status                   = '0;
      status[FLAG_FAULT_BIT]   = fault;
      status[FLAG_OTW_BIT]     = otw;
      status[FLAG_STALLED_BIT] = stalled;
      return status;
   endfunction

endpackage

// File: rtl/dcm_pulse_tracker_if.sv
// dcm_pulse_tracker_if
// Host-side bundle between one channel's control logic and its tracker.
//   pos_load / pos_load_value   position preset strobe and value (master drives)
//   flag_clear                  sticky flag clear strobe (master drives)
//   position, speed, speed_valid, fault_flag, otw_flag, stalled
//                               measurement results (slave drives)
// master = channel control logic, slave = dcm_pulse_tracker.
interface dcm_pulse_tracker_if;
   import dcm_pkg::*;

   logic               pos_load;
   logic [POS_W-1:0]   pos_load_value;
   logic               flag_clear;
   logic [POS_W-1:0]   position;
   logic [SPEED_W-1:0] speed;
   logic               speed_valid;
   logic               fault_flag;
   logic               otw_flag;
   logic               stalled;

   modport master (
      output pos_load, pos_load_value, flag_clear,
      input  position, speed, speed_valid, fault_flag, otw_flag, stalled
   );

   modport slave (
      input  pos_load, pos_load_value, flag_clear,
      output position, speed, speed_valid, fault_flag, otw_flag, stalled
   );

endinterface

// File: rtl/dcm_sync_filter.sv
// dcm_sync_filter
// Brings one asynchronous motor pin into the clk domain and removes glitches.
//   clk, reset   system clock, synchronous active-high reset
//   raw_in       asynchronous pin
//   filt_out     filtered level
//   rise         one-cycle strobe, registered alongside filt_out going high
// The filtered output only follows the synchronized level after that level
// has disagreed with it for FILTER_LEN consecutive cycles.
module dcm_sync_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic filt_out,
   output logic rise
);

   // The run counter reaches FILTER_LEN-1 on the cycle before the change is
   // accepted, so the accepting cycle itself is the FILTER_LEN-th disagreement.
   localparam logic [3:0] RUN_LAST = 4'(FILTER_LEN - 1);

   logic       sync_ff1;
   logic       sync_ff2;
   logic [3:0] run_cnt;

   // Two-flop synchronizer followed by the run-length filter. Any cycle where
   // the synchronized level agrees with the filtered one restarts the run, so
   // short glitches never accumulate. The rise strobe is registered together
   // with the filtered level so downstream logic sees a clean single pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_ff1 <= 1'b0;
         sync_ff2 <= 1'b0;
         run_cnt  <= '0;
         filt_out <= 1'b0;
         rise     <= 1'b0;
      end else begin
         sync_ff1 <= raw_in;
         sync_ff2 <= sync_ff1;
         rise     <= 1'b0;
         if (sync_ff2 != filt_out) begin
            if (run_cnt == RUN_LAST) begin
               filt_out <= sync_ff2;
               rise     <= sync_ff2;
               run_cnt  <= '0;
            end else begin
               run_cnt <= run_cnt + 4'd1;
            end
         end else begin
            run_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/dcm_pulse_tracker.sv
// dcm_pulse_tracker
// Per-channel motor feedback front end: position count, windowed speed and
// sticky status flags for one DC motor channel.
//   clk, reset                 system clock, synchronous active-high reset
//   motor_pulse                raw encoder/tach pin (asynchronous)
//   motor_fault, motor_otw     raw driver fault / over-temp warning pins
//   drive_left, drive_right    channel's current motor drive outputs
//   host (slave)               pos_load/pos_load_value/flag_clear in,
//                              position/speed/speed_valid/flags out
module dcm_pulse_tracker
   import dcm_pkg::*;
#(
   parameter int FILTER_LEN    = 4,
   parameter int WINDOW_CYCLES = 1000,
   parameter int STALL_WINDOWS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 motor_pulse,
   input  logic                 motor_fault,
   input  logic                 motor_otw,
   input  logic                 drive_left,
   input  logic                 drive_right,
   dcm_pulse_tracker_if.slave   host
);

   localparam int               WIN_W     = $clog2(WINDOW_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [3:0]       STALL_MAX = 4'(STALL_WINDOWS);

   logic               pulse_filt;
   logic               pulse_rise;
   logic               fault_filt;
   logic               fault_rise;
   logic               otw_filt;
   logic               otw_rise;
   logic               unused_filter_outs;

   drive_mode_t        drive_mode;
   logic               dir_up;
   logic [POS_W-1:0]   position_q;

   logic [WIN_W-1:0]   win_cnt;
   logic [SPEED_W-1:0] pulse_cnt;
   logic [SPEED_W-1:0] pulse_cnt_inc;
   logic [SPEED_W-1:0] speed_q;
   logic               speed_valid_q;
   logic               window_end;

   logic [3:0]         zero_cnt;
   logic [3:0]         zero_cnt_next;
   logic               stall_set;

   logic               fault_flag_q;
   logic               otw_flag_q;
   logic               stalled_q;

   dcm_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_pulse_filter (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (motor_pulse),
      .filt_out (pulse_filt),
      .rise     (pulse_rise)
   );

   dcm_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_fault_filter (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (motor_fault),
      .filt_out (fault_filt),
      .rise     (fault_rise)
   );

   dcm_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_otw_filter (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (motor_otw),
      .filt_out (otw_filt),
      .rise     (otw_rise)
   );

   // Pulses only need the edge and the flags only need the level; the other
   // filter outputs are deliberately left unused.
   assign unused_filter_outs = &{1'b0, pulse_filt, fault_rise, otw_rise};

   assign drive_mode = drive_mode_t'({drive_left, drive_right});
   assign window_end = (win_cnt == WIN_LAST);

   // Next values for the window bookkeeping. The edge arriving in the
   // terminal cycle is folded into pulse_cnt_inc so it counts toward the
   // window that is closing. The zero-window run saturates at STALL_WINDOWS
   // so a long stall keeps re-asserting the set condition.
   always_comb begin
      pulse_cnt_inc = pulse_cnt;
      if (pulse_rise && (pulse_cnt != '1)) begin
         pulse_cnt_inc = pulse_cnt + SPEED_W'(1);
      end

      zero_cnt_next = '0;
      if ((pulse_cnt_inc == '0) && (drive_left ^ drive_right)) begin
         zero_cnt_next = (zero_cnt == STALL_MAX) ? zero_cnt : zero_cnt + 4'd1;
      end

      stall_set = window_end && (zero_cnt_next == STALL_MAX);
   end

   // Direction and position. A load in the same cycle as a pulse edge wins
   // and the edge is dropped from the position count. The step direction is
   // the registered dir_up, so a drive change only affects later edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         dir_up     <= 1'b1;
         position_q <= '0;
      end else begin
         case (drive_mode)
            DRIVE_RIGHT: dir_up <= 1'b1;
            DRIVE_LEFT:  dir_up <= 1'b0;
            default:     dir_up <= dir_up;
         endcase

         if (host.pos_load) begin
            position_q <= host.pos_load_value;
         end else if (pulse_rise) begin
            position_q <= dir_up ? position_q + POS_W'(1)
                                 : position_q - POS_W'(1);
         end
      end
   end

   // Free-running speed window. At the terminal count the saturated pulse
   // count is published, speed_valid strobes for one cycle and the stall run
   // is updated from this window's result.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt       <= '0;
         pulse_cnt     <= '0;
         speed_q       <= '0;
         speed_valid_q <= 1'b0;
         zero_cnt      <= '0;
      end else begin
         if (window_end) begin
            win_cnt       <= '0;
            pulse_cnt     <= '0;
            speed_q       <= pulse_cnt_inc;
            speed_valid_q <= 1'b1;
            zero_cnt      <= zero_cnt_next;
         end else begin
            win_cnt       <= win_cnt + WIN_W'(1);
            pulse_cnt     <= pulse_cnt_inc;
            speed_valid_q <= 1'b0;
         end
      end
   end

   // Sticky flags: a set condition in the same cycle as flag_clear wins, so
   // a fault that is still present cannot be cleared away.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_flag_q <= 1'b0;
         otw_flag_q   <= 1'b0;
         stalled_q    <= 1'b0;
      end else begin
         fault_flag_q <= fault_filt | (fault_flag_q & ~host.flag_clear);
         otw_flag_q   <= otw_filt   | (otw_flag_q   & ~host.flag_clear);
         stalled_q    <= stall_set  | (stalled_q    & ~host.flag_clear);
      end
   end

   assign host.position    = position_q;
   assign host.speed       = speed_q;
   assign host.speed_valid = speed_valid_q;
   assign host.fault_flag  = fault_flag_q;
   assign host.otw_flag    = otw_flag_q;
   assign host.stalled     = stalled_q;

endmodule

// File: tb/tb_dcm_pulse_tracker.sv
// tb_dcm_pulse_tracker
// Directed bench for dcm_pulse_tracker. A cycle-level behavioural model
// predicts every output from pulse timing arithmetic (a qualified pin pulse
// lands on position FILTER_LEN+2 edges after its first sampled high), and a
// compare process checks the main DUT against it every cycle. A second DUT
// with FILTER_LEN=1 is used for the saturating speed case.
module tb_dcm_pulse_tracker;
   import dcm_pkg::*;

   localparam int FILT      = 4;
   localparam int WIN       = 1000;
   localparam int STALL     = 4;
   localparam int FAST_FILT = 1;

   logic clk = 1'b0;
   logic reset;
   logic motor_pulse;
   logic motor_fault;
   logic motor_otw;
   logic drive_left;
   logic drive_right;
   logic fast_pulse;

   int n_compared   = 0;
   int n_mismatched = 0;

   dcm_pulse_tracker_if host ();
   dcm_pulse_tracker_if fast_host ();

   dcm_pulse_tracker #(
      .FILTER_LEN    (FILT),
      .WINDOW_CYCLES (WIN),
      .STALL_WINDOWS (STALL)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .motor_pulse (motor_pulse),
      .motor_fault (motor_fault),
      .motor_otw   (motor_otw),
      .drive_left  (drive_left),
      .drive_right (drive_right),
      .host        (host.slave)
   );

   dcm_pulse_tracker #(
      .FILTER_LEN    (FAST_FILT),
      .WINDOW_CYCLES (WIN),
      .STALL_WINDOWS (STALL)
   ) u_fast (
      .clk         (clk),
      .reset       (reset),
      .motor_pulse (fast_pulse),
      .motor_fault (1'b0),
      .motor_otw   (1'b0),
      .drive_left  (1'b0),
      .drive_right (1'b1),
      .host        (fast_host.slave)
   );

   always #5 clk = ~clk;

   // Behavioural model state. Expected events are keyed by the index of the
   // clock edge at which the DUT must act on them.
   int unsigned edge_n   = 0;
   int unsigned rel_edge = 0;
   bit          rise_at  [int unsigned];
   bit          fault_at [int unsigned];
   bit          otw_at   [int unsigned];
   bit          m_ready  = 1'b0;
   logic [23:0] m_pos;
   logic [7:0]  m_speed;
   bit          m_sv, m_fault, m_otw, m_stalled, m_dir;
   int          m_pc, m_zw;

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // Drives one pin high for hi cycles then low for lo cycles, registering
   // the events the DUT must produce. pin: 0=pulse, 1=fault, 2=otw.
   task automatic apply_stimulus(input int pin, input int hi, input int lo);
      int unsigned first_hi;
      first_hi = edge_n + 1;
      if (hi >= FILT) begin
         case (pin)
            0: rise_at[first_hi + FILT + 2] = 1'b1;
            1: for (int unsigned e = first_hi + FILT + 2; e <= first_hi + hi + FILT + 1; e++)
                  fault_at[e] = 1'b1;
            default: for (int unsigned e = first_hi + FILT + 2; e <= first_hi + hi + FILT + 1; e++)
                  otw_at[e] = 1'b1;
         endcase
      end
      case (pin)
         0: motor_pulse = 1'b1;
         1: motor_fault = 1'b1;
         default: motor_otw = 1'b1;
      endcase
      repeat (hi) @(negedge clk);
      motor_pulse = 1'b0;
      motor_fault = 1'b0;
      motor_otw   = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   // Advances to the negedge right after the model's next window end.
   task automatic wait_window_end();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_sv && n < 2 * WIN);
      check_output("window_end_seen", 32'(m_sv), 32'd1);
   endtask

   task automatic strobe_flag_clear();
      host.flag_clear = 1'b1;
      @(negedge clk);
      host.flag_clear = 1'b0;
   endtask

   // Model: evaluated at every rising edge from the inputs the bench is
   // holding; the outputs it predicts are those visible after that edge.
   initial begin : model
      bit          r, wend, st_set;
      int          cnt;
      forever begin
         @(posedge clk);
         edge_n = edge_n + 1;
         if (reset) begin
            m_pos = '0; m_speed = '0; m_sv = 0; m_fault = 0; m_otw = 0;
            m_stalled = 0; m_dir = 1; m_pc = 0; m_zw = 0;
            rise_at.delete(); fault_at.delete(); otw_at.delete();
            rel_edge = edge_n + 1;
            m_ready  = 1'b1;
         end else begin
            r    = rise_at.exists(edge_n) ? 1'b1 : 1'b0;
            wend = (((edge_n - rel_edge) % WIN) == WIN - 1);
            if (host.pos_load)  m_pos = host.pos_load_value;
            else if (r)         m_pos = m_dir ? m_pos + 24'd1 : m_pos - 24'd1;
            if (drive_right && !drive_left)      m_dir = 1'b1;
            else if (drive_left && !drive_right) m_dir = 1'b0;
            cnt    = m_pc + (r ? 1 : 0);
            m_sv   = wend;
            st_set = 1'b0;
            if (wend) begin
               m_speed = (cnt > 255) ? 8'd255 : 8'(cnt);
               if (cnt == 0 && (drive_left ^ drive_right)) begin
                  if (m_zw < STALL) m_zw++;
               end else begin
                  m_zw = 0;
               end
               st_set = (m_zw >= STALL);
               m_pc   = 0;
            end else begin
               m_pc = cnt;
            end
            m_fault   = fault_at.exists(edge_n) || (m_fault && !host.flag_clear);
            m_otw     = otw_at.exists(edge_n)   || (m_otw && !host.flag_clear);
            m_stalled = st_set || (m_stalled && !host.flag_clear);
         end
      end
   end

   // Every-cycle comparison of the main DUT against the model.
   initial begin : compare
      forever begin
         @(negedge clk);
         if (m_ready) begin
            check_output("position",    32'(host.position),    32'(m_pos));
            check_output("speed",       32'(host.speed),       32'(m_speed));
            check_output("speed_valid", 32'(host.speed_valid), 32'(m_sv));
            check_output("fault_flag",  32'(host.fault_flag),  32'(m_fault));
            check_output("otw_flag",    32'(host.otw_flag),    32'(m_otw));
            check_output("stalled",     32'(host.stalled),     32'(m_stalled));
         end
      end
   end

   initial begin : stimulus
      reset       = 1'b1;
      motor_pulse = 1'b0;
      motor_fault = 1'b0;
      motor_otw   = 1'b0;
      drive_left  = 1'b0;
      drive_right = 1'b1;
      fast_pulse  = 1'b0;
      host.pos_load            = 1'b0;
      host.pos_load_value      = '0;
      host.flag_clear          = 1'b0;
      fast_host.pos_load       = 1'b0;
      fast_host.pos_load_value = '0;
      fast_host.flag_clear     = 1'b0;

      repeat (3) @(negedge clk);
      check_output("reset_position", 32'(host.position), 32'd0);
      check_output("reset_speed",    32'(host.speed),    32'd0);
      check_output("reset_flags",    {29'd0, host.fault_flag, host.otw_flag, host.stalled}, 32'd0);
      reset = 1'b0;

      // Counting up, with the pin-to-position latency pinned on the first pulse.
      rise_at[edge_n + 1 + FILT + 2] = 1'b1;
      motor_pulse = 1'b1;
      repeat (FILT + 2) @(negedge clk);
      check_output("latency_before_step", 32'(host.position), 32'd0);
      @(negedge clk);
      check_output("latency_at_step", 32'(host.position), 32'd1);
      repeat (12 - FILT - 3) @(negedge clk);
      motor_pulse = 1'b0;
      repeat (378) @(negedge clk);
      for (int i = 0; i < 4; i++) apply_stimulus(0, 12, 378);
      check_output("count_up_5", 32'(host.position), 32'd5);

      // Counting down.
      drive_right = 1'b0;
      drive_left  = 1'b1;
      for (int i = 0; i < 2; i++) apply_stimulus(0, 12, 378);
      check_output("count_down_3", 32'(host.position), 32'd3);

      // Glitches shorter than the filter are ignored; a 4-cycle pulse is not.
      for (int i = 0; i < 10; i++) apply_stimulus(0, 3, 10);
      check_output("glitch_reject", 32'(host.position), 32'd3);
      drive_left  = 1'b0;
      drive_right = 1'b1;
      apply_stimulus(0, 4, 20);
      check_output("min_pulse_count", 32'(host.position), 32'd4);

      // Wrap below zero and above all-ones.
      drive_right = 1'b0;
      drive_left  = 1'b1;
      host.pos_load_value = 24'h000000;
      host.pos_load       = 1'b1;
      @(negedge clk);
      host.pos_load = 1'b0;
      check_output("load_zero", 32'(host.position), 32'd0);
      apply_stimulus(0, 12, 20);
      check_output("wrap_down", 32'(host.position), 32'h00FFFFFF);
      drive_left  = 1'b0;
      drive_right = 1'b1;
      host.pos_load_value = 24'hFFFFFF;
      host.pos_load       = 1'b1;
      @(negedge clk);
      host.pos_load = 1'b0;
      apply_stimulus(0, 12, 20);
      check_output("wrap_up", 32'(host.position), 32'd0);

      // Load landing in the same cycle as a filtered edge.
      rise_at[edge_n + 1 + FILT + 2] = 1'b1;
      motor_pulse = 1'b1;
      repeat (FILT + 2) @(negedge clk);
      host.pos_load_value = 24'h123456;
      host.pos_load       = 1'b1;
      @(negedge clk);
      host.pos_load = 1'b0;
      check_output("load_beats_edge", 32'(host.position), 32'h00123456);
      repeat (12 - FILT - 3) @(negedge clk);
      motor_pulse = 1'b0;
      repeat (20) @(negedge clk);
      check_output("load_edge_dropped", 32'(host.position), 32'h00123456);

      // Seven pulses inside one window.
      wait_window_end();
      for (int i = 0; i < 7; i++) apply_stimulus(0, 12, 130);
      wait_window_end();
      check_output("speed_7", 32'(host.speed), 32'd7);
      check_output("speed_7_valid", 32'(host.speed_valid), 32'd1);

      // Stall: two empty windows, a pulse restarts the run, then four empty.
      wait_window_end();
      wait_window_end();
      check_output("no_stall_2", 32'(host.stalled), 32'd0);
      apply_stimulus(0, 12, 20);
      wait_window_end();
      for (int i = 0; i < 3; i++) wait_window_end();
      check_output("no_stall_3", 32'(host.stalled), 32'd0);
      repeat (WIN - 1) @(negedge clk);
      check_output("stall_edge_before", 32'(host.stalled), 32'd0);
      @(negedge clk);
      check_output("stall_set", 32'(host.stalled), 32'd1);
      drive_right = 1'b0;
      repeat (5) @(negedge clk);
      check_output("stall_sticky", 32'(host.stalled), 32'd1);
      strobe_flag_clear();
      check_output("stall_cleared", 32'(host.stalled), 32'd0);

      // Saturating speed on the FILTER_LEN=1 instance: 330 pulses in a window.
      wait_window_end();
      for (int i = 0; i < 330; i++) begin
         fast_pulse = 1'b1;
         @(negedge clk);
         fast_pulse = 1'b0;
         repeat (2) @(negedge clk);
      end
      wait_window_end();
      check_output("fast_speed_sat", 32'(fast_host.speed), 32'd255);
      check_output("fast_speed_valid", 32'(fast_host.speed_valid), 32'd1);
      check_output("fast_position", 32'(fast_host.position), 32'd330);

      // Sticky fault and otw flags.
      apply_stimulus(1, 10, 20);
      check_output("fault_sticky", 32'(host.fault_flag), 32'd1);
      apply_stimulus(2, 6, 20);
      check_output("otw_sticky", 32'(host.otw_flag), 32'd1);
      fork
         apply_stimulus(1, 40, 20);
         begin
            repeat (20) @(negedge clk);
            strobe_flag_clear();
            check_output("fault_set_wins", 32'(host.fault_flag), 32'd1);
            check_output("otw_cleared", 32'(host.otw_flag), 32'd0);
         end
      join
      strobe_flag_clear();
      check_output("fault_cleared", 32'(host.fault_flag), 32'd0);

      // Reset in the middle of a window restarts everything.
      drive_right = 1'b1;
      apply_stimulus(0, 12, 200);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_output("mid_reset_position", 32'(host.position), 32'd0);
      check_output("mid_reset_speed",    32'(host.speed),    32'd0);
      reset = 1'b0;
      repeat (WIN - 1) @(negedge clk);
      check_output("first_valid_before", 32'(host.speed_valid), 32'd0);
      @(negedge clk);
      check_output("first_valid_at", 32'(host.speed_valid), 32'd1);
      check_output("first_valid_speed", 32'(host.speed), 32'd0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
